// File: rtl/ps2_key_tracker.sv
// PS/2 keyboard receiver: deframes 11-bit packets, decodes E0/F0 prefixes, tracks NUM_KEYS key states.
// Latency: 2 CLK sync + up to CLK_DIV tick quantisation; outputs register on the edge ending the CHECK tick.
// Backpressure: none; the keyboard cannot be stalled, so every decoded byte is presented as a one-CLK pulse.
module ps2_key_tracker #(
    parameter int CLK_DIV       = 250,
    parameter int TIMEOUT_TICKS = 4000,
    parameter int NUM_KEYS      = 4,
    parameter logic [NUM_KEYS*9-1:0] KEY_CODES = {9'h174, 9'h16B, 9'h172, 9'h175}
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                PS2_CLK,
    input  logic                PS2_DATA,
    output logic [NUM_KEYS-1:0] KEY_DOWN,
    output logic [NUM_KEYS-1:0] KEY_PRESS,
    output logic                CODE_VALID,
    output logic [7:0]          CODE,
    output logic                CODE_EXT,
    output logic                CODE_BREAK,
    output logic                FRAME_ERR,
    output logic [7:0]          ERR_COUNT
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int TO_W  = $clog2(TIMEOUT_TICKS + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RECV  = 2'd1,
        ST_CHECK = 2'd2
    } state_t;

    logic [1:0]          ps2_clk_sync_q, ps2_data_sync_q;
    logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
    logic                prev_clk_q, prev_clk_d;
    state_t              state_q, state_d;
    logic [10:0]         frame_q, frame_d;
    logic [3:0]          bitcnt_q, bitcnt_d;
    logic [TO_W-1:0]     idle_cnt_q, idle_cnt_d;
    logic                ext_q, ext_d;
    logic                brk_q, brk_d;
    logic                code_valid_q, code_valid_d;
    logic [7:0]          code_q, code_d;
    logic                code_ext_q, code_ext_d;
    logic                code_break_q, code_break_d;
    logic                frame_err_q, frame_err_d;
    logic [7:0]          err_count_q, err_count_d;
    logic [NUM_KEYS-1:0] key_down_q, key_down_d;
    logic [NUM_KEYS-1:0] key_press_q, key_press_d;

    logic       tick;
    logic       fall;
    logic       ps2_clk_s;
    logic       ps2_data_s;
    logic       byte_vld;
    logic       rx_err;
    logic [7:0] rx_byte;

    assign ps2_clk_s  = ps2_clk_sync_q[1];
    assign ps2_data_s = ps2_data_sync_q[1];
    assign tick       = (div_cnt_q == DIV_W'(CLK_DIV - 1));
    assign fall       = tick && !ps2_clk_s && prev_clk_q;
    assign rx_byte    = frame_q[8:1];

    always_comb begin
        div_cnt_d  = tick ? '0 : div_cnt_q + 1'b1;
        prev_clk_d = tick ? ps2_clk_s : prev_clk_q;
    end

    // Receiver: bits land at frame[bitcnt], so frame[0] is the start bit.
    always_comb begin
        state_d    = state_q;
        frame_d    = frame_q;
        bitcnt_d   = bitcnt_q;
        idle_cnt_d = idle_cnt_q;
        byte_vld   = 1'b0;
        rx_err     = 1'b0;
        if (tick) begin
            case (state_q)
                ST_IDLE: begin
                    if (fall) begin
                        frame_d    = '0;
                        frame_d[0] = ps2_data_s;
                        bitcnt_d   = 4'd1;
                        idle_cnt_d = '0;
                        state_d    = ST_RECV;
                    end
                end
                ST_RECV: begin
                    if (fall) begin
                        frame_d[bitcnt_q] = ps2_data_s;
                        bitcnt_d          = bitcnt_q + 4'd1;
                        idle_cnt_d        = '0;
                        if (bitcnt_q == 4'd10) begin
                            state_d = ST_CHECK;
                        end
                    end else if (idle_cnt_q == TO_W'(TIMEOUT_TICKS - 1)) begin
                        rx_err     = 1'b1;
                        idle_cnt_d = '0;
                        state_d    = ST_IDLE;
                    end else begin
                        idle_cnt_d = idle_cnt_q + 1'b1;
                    end
                end
                ST_CHECK: begin
                    state_d = ST_IDLE;
                    if (!frame_q[0] && frame_q[10] && (^frame_q[9:1])) begin
                        byte_vld = 1'b1;
                    end else begin
                        rx_err = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Decoder and key table; both resolve in the same cycle as the CHECK tick.
    always_comb begin
        ext_d        = ext_q;
        brk_d        = brk_q;
        code_valid_d = 1'b0;
        code_d       = code_q;
        code_ext_d   = code_ext_q;
        code_break_d = code_break_q;
        frame_err_d  = rx_err;
        err_count_d  = err_count_q;
        key_down_d   = key_down_q;
        key_press_d  = '0;

        if (rx_err) begin
            ext_d = 1'b0;
            brk_d = 1'b0;
            if (err_count_q != 8'hFF) begin
                err_count_d = err_count_q + 8'd1;
            end
        end else if (byte_vld) begin
            case (rx_byte)
                8'hE0: ext_d = 1'b1;
                8'hF0: brk_d = 1'b1;
                8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF: begin
                    ext_d = 1'b0;
                    brk_d = 1'b0;
                end
                default: begin
                    code_valid_d = 1'b1;
                    code_d       = rx_byte;
                    code_ext_d   = ext_q;
                    code_break_d = brk_q;
                    ext_d        = 1'b0;
                    brk_d        = 1'b0;
                end
            endcase
        end

        if (code_valid_d) begin
            for (int i = 0; i < NUM_KEYS; i++) begin
                if ({code_ext_d, code_d} == KEY_CODES[9*i +: 9]) begin
                    if (code_break_d) begin
                        key_down_d[i] = 1'b0;
                    end else begin
                        key_press_d[i] = !key_down_q[i];
                        key_down_d[i]  = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            ps2_clk_sync_q  <= 2'b11;
            ps2_data_sync_q <= 2'b11;
            div_cnt_q       <= '0;
            prev_clk_q      <= 1'b1;
            state_q         <= ST_IDLE;
            frame_q         <= '0;
            bitcnt_q        <= '0;
            idle_cnt_q      <= '0;
            ext_q           <= 1'b0;
            brk_q           <= 1'b0;
            code_valid_q    <= 1'b0;
            code_q          <= '0;
            code_ext_q      <= 1'b0;
            code_break_q    <= 1'b0;
            frame_err_q     <= 1'b0;
            err_count_q     <= '0;
            key_down_q      <= '0;
            key_press_q     <= '0;
        end else begin
            ps2_clk_sync_q  <= {ps2_clk_sync_q[0], PS2_CLK};
            ps2_data_sync_q <= {ps2_data_sync_q[0], PS2_DATA};
            div_cnt_q       <= div_cnt_d;
            prev_clk_q      <= prev_clk_d;
            state_q         <= state_d;
            frame_q         <= frame_d;
            bitcnt_q        <= bitcnt_d;
            idle_cnt_q      <= idle_cnt_d;
            ext_q           <= ext_d;
            brk_q           <= brk_d;
            code_valid_q    <= code_valid_d;
            code_q          <= code_d;
            code_ext_q      <= code_ext_d;
            code_break_q    <= code_break_d;
            frame_err_q     <= frame_err_d;
            err_count_q     <= err_count_d;
            key_down_q      <= key_down_d;
            key_press_q     <= key_press_d;
        end
    end

    assign KEY_DOWN   = key_down_q;
    assign KEY_PRESS  = key_press_q;
    assign CODE_VALID = code_valid_q;
    assign CODE       = code_q;
    assign CODE_EXT   = code_ext_q;
    assign CODE_BREAK = code_break_q;
    assign FRAME_ERR  = frame_err_q;
    assign ERR_COUNT  = err_count_q;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Scoreboard bench for ps2_key_tracker: directed PS/2 frames push expected events,
// a negedge monitor pops and compares whenever CODE_VALID or FRAME_ERR fires.
module tb_ps2_key_tracker;

    localparam int HALF = 8;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       PS2_CLK = 1'b1;
    logic       PS2_DATA = 1'b1;
    logic [3:0] KEY_DOWN;
    logic [3:0] KEY_PRESS;
    logic       CODE_VALID;
    logic [7:0] CODE;
    logic       CODE_EXT;
    logic       CODE_BREAK;
    logic       FRAME_ERR;
    logic [7:0] ERR_COUNT;

    ps2_key_tracker #(
        .CLK_DIV       (4),
        .TIMEOUT_TICKS (40)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .PS2_CLK    (PS2_CLK),
        .PS2_DATA   (PS2_DATA),
        .KEY_DOWN   (KEY_DOWN),
        .KEY_PRESS  (KEY_PRESS),
        .CODE_VALID (CODE_VALID),
        .CODE       (CODE),
        .CODE_EXT   (CODE_EXT),
        .CODE_BREAK (CODE_BREAK),
        .FRAME_ERR  (FRAME_ERR),
        .ERR_COUNT  (ERR_COUNT)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        bit         is_err;
        logic [7:0] code;
        bit         ext;
        bit         brk;
        logic [3:0] kd;
        logic [3:0] kp;
        logic [7:0] ec;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    int   errs  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] sat_errs();
        return (errs > 255) ? 8'd255 : 8'(errs);
    endfunction

    task automatic exp_code(input logic [7:0] code, input bit ext, input bit brk,
                            input logic [3:0] kd, input logic [3:0] kp);
        exp_t e;
        e.is_err = 1'b0; e.code = code; e.ext = ext; e.brk = brk;
        e.kd = kd; e.kp = kp; e.ec = sat_errs();
        q.push_back(e);
    endtask

    task automatic exp_err(input logic [3:0] kd);
        exp_t e;
        errs++;
        e.is_err = 1'b1; e.code = '0; e.ext = 1'b0; e.brk = 1'b0;
        e.kd = kd; e.kp = 4'b0000; e.ec = sat_errs();
        q.push_back(e);
    endtask

    task automatic ps2_bit(input logic b);
        PS2_DATA = b;
        repeat (HALF) @(negedge CLK);
        PS2_CLK = 1'b0;
        repeat (HALF) @(negedge CLK);
        PS2_CLK = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par);
        logic par;
        par = (~^b) ^ bad_par;
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(par);
        ps2_bit(1'b1);
        PS2_DATA = 1'b1;
        repeat (40) @(negedge CLK);
    endtask

    task automatic send_partial(input int n);
        for (int i = 0; i < n; i++) ps2_bit(1'b0);
        PS2_DATA = 1'b1;
        repeat (200) @(negedge CLK);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (q.size() != 0 && n < 5000) begin
            @(negedge CLK);
            n++;
        end
        check(name, 32'(q.size()), 32'd0);
    endtask

    // Monitor: every CODE_VALID/FRAME_ERR must match the oldest expectation.
    always @(negedge CLK) begin
        if (!RST) begin
            if (CODE_VALID || FRAME_ERR) begin
                if (q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_event: got code_valid=%0b frame_err=%0b code=%0h expected none",
                             CODE_VALID, FRAME_ERR, CODE);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("frame_err", 32'(FRAME_ERR), 32'(e.is_err));
                    check("code_valid", 32'(CODE_VALID), 32'(!e.is_err));
                    if (!e.is_err) begin
                        check("code", 32'(CODE), 32'(e.code));
                        check("code_ext", 32'(CODE_EXT), 32'(e.ext));
                        check("code_break", 32'(CODE_BREAK), 32'(e.brk));
                    end
                    check("key_press", 32'(KEY_PRESS), 32'(e.kp));
                    check("key_down", 32'(KEY_DOWN), 32'(e.kd));
                    check("err_count", 32'(ERR_COUNT), 32'(e.ec));
                end
            end else if (KEY_PRESS != 4'b0000) begin
                tests++;
                fails++;
                $display("FAIL stray_press: got %0b expected 0000", KEY_PRESS);
            end
        end
    end

    initial begin
        repeat (5) @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        check("reset_outputs", 32'({KEY_DOWN, KEY_PRESS, CODE_VALID, CODE, CODE_EXT, CODE_BREAK, FRAME_ERR}), 32'd0);
        check("reset_err_count", 32'(ERR_COUNT), 32'd0);

        // plain make code, not in the key table
        exp_code(8'h1C, 0, 0, 4'b0000, 4'b0000);
        send_frame(8'h1C, 0);

        // up pressed, typematic repeat, released
        send_frame(8'hE0, 0);
        exp_code(8'h75, 1, 0, 4'b0001, 4'b0001);
        send_frame(8'h75, 0);
        send_frame(8'hE0, 0);
        exp_code(8'h75, 1, 0, 4'b0001, 4'b0000);
        send_frame(8'h75, 0);
        send_frame(8'hE0, 0);
        send_frame(8'hF0, 0);
        exp_code(8'h75, 1, 1, 4'b0000, 4'b0000);
        send_frame(8'h75, 0);

        // up + right together, release right, then release up with F0 before E0
        send_frame(8'hE0, 0);
        exp_code(8'h75, 1, 0, 4'b0001, 4'b0001);
        send_frame(8'h75, 0);
        send_frame(8'hE0, 0);
        exp_code(8'h74, 1, 0, 4'b1001, 4'b1000);
        send_frame(8'h74, 0);
        send_frame(8'hE0, 0);
        send_frame(8'hF0, 0);
        exp_code(8'h74, 1, 1, 4'b0001, 4'b0000);
        send_frame(8'h74, 0);
        send_frame(8'hF0, 0);
        send_frame(8'hE0, 0);
        exp_code(8'h75, 1, 1, 4'b0000, 4'b0000);
        send_frame(8'h75, 0);

        // parity error
        exp_err(4'b0000);
        send_frame(8'h1C, 1);

        // error clears a pending E0
        send_frame(8'hE0, 0);
        exp_err(4'b0000);
        send_frame(8'h12, 1);
        exp_code(8'h75, 0, 0, 4'b0000, 4'b0000);
        send_frame(8'h75, 0);

        // dropped byte AA clears a pending F0
        send_frame(8'hF0, 0);
        send_frame(8'hAA, 0);
        exp_code(8'h1C, 0, 0, 4'b0000, 4'b0000);
        send_frame(8'h1C, 0);

        // timeout on a partial frame, then a clean frame
        exp_err(4'b0000);
        send_partial(5);
        exp_code(8'h29, 0, 0, 4'b0000, 4'b0000);
        send_frame(8'h29, 0);
        drain("drain_main");

        // saturate the error counter
        for (int i = 0; i < 260; i++) begin
            exp_err(4'b0000);
            send_partial(1);
        end
        drain("drain_errors");
        check("err_count_sat", 32'(ERR_COUNT), 32'd255);

        // reset mid-frame while up is held
        send_frame(8'hE0, 0);
        exp_code(8'h75, 1, 0, 4'b0001, 4'b0001);
        send_frame(8'h75, 0);
        drain("drain_pre_reset");
        for (int i = 0; i < 6; i++) ps2_bit(1'b0);
        PS2_DATA = 1'b1;
        RST = 1'b1;
        @(negedge CLK);
        check("midframe_reset_outputs",
              32'({KEY_DOWN, KEY_PRESS, CODE_VALID, CODE, CODE_EXT, CODE_BREAK, FRAME_ERR}), 32'd0);
        check("midframe_reset_err_count", 32'(ERR_COUNT), 32'd0);
        errs = 0;
        RST = 1'b0;
        repeat (40) @(negedge CLK);

        send_frame(8'hE0, 0);
        exp_code(8'h75, 1, 0, 4'b0001, 4'b0001);
        send_frame(8'h75, 0);
        drain("drain_post_reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ps2_key_tracker.md
# ps2_key_tracker

Parametrised PS/2 keyboard receiver that replaces the single-key detector. It oversamples the PS/2 clock and data lines, deframes 11-bit packets, and checks start, stop and odd parity with a timeout. It decodes E0 (extended) and F0 (break) prefixes and tracks the up/down state of NUM_KEYS configurable keys in parallel. It sits between the board PS/2 pins and the game logic, and supplies per-key levels, per-key press pulses and a raw decoded-code stream.

## Interface
- CLK_DIV, 250: CLK cycles per sampling tick (≥2).
- TIMEOUT_TICKS, 4000: ticks without a PS2_CLK falling edge before a partial frame is discarded.
- NUM_KEYS, 4: number of tracked keys (1..16).
- KEY_CODES, {9'h174,9'h16B,9'h172,9'h175}: packed NUM_KEYS×9. Entry i is KEY_CODES[9i+8:9i]; bit 8 is the extended flag and bits 7:0 the scan code. The default maps key0=up, key1=down, key2=left, key3=right.
- CLK  in  1  board clock; the only clock.
- RST  in  1  synchronous, active-high reset.
- PS2_CLK  in  1  raw keyboard clock, asynchronous.
- PS2_DATA  in  1  raw keyboard data, asynchronous.
- KEY_DOWN  out  NUM_KEYS  level; 1 while key i is held.
- KEY_PRESS  out  NUM_KEYS  one-CLK pulse on a 0→1 transition of KEY_DOWN[i].
- CODE_VALID  out  1  one-CLK pulse; a non-prefix byte has been decoded.
- CODE  out  8  decoded scan code; held until the next CODE_VALID.
- CODE_EXT  out  1  E0 preceded CODE; held with CODE.
- CODE_BREAK  out  1  F0 preceded CODE; held with CODE.
- FRAME_ERR  out  1  one-CLK pulse on a start, stop, parity or timeout error.
- ERR_COUNT  out  8  error count, saturates at 255.

## Operation
- Synchronisation: PS2_CLK and PS2_DATA pass through 2-flop synchronisers on CLK.
- Tick generator: a divider counts 0..CLK_DIV-1. The tick is high for one CLK when the count is CLK_DIV-1. All frame logic advances only on tick cycles.
- Edge detection: on each tick, a falling edge is sync PS2_CLK=0 with the previous ticked sample=1. The previous ticked sample resets to 1.
- Receiver FSM:
  - IDLE: a falling edge shifts in bit 0 and moves to RECV with bitcnt=1.
  - RECV: each falling edge shifts PS2_DATA into frame[10:0] LSB-first and increments bitcnt. At bitcnt=11 go to CHECK.
  - RECV timeout: the idle-tick counter clears on each falling edge and increments on other ticks. When it reaches TIMEOUT_TICKS, assert FRAME_ERR, discard the frame and go to IDLE.
  - CHECK (one tick): the frame is valid iff frame[0]=0, frame[10]=1 and ^frame[9:1]=1. A valid frame passes byte frame[8:1] to the decoder. An invalid frame raises FRAME_ERR. Return to IDLE.
- Decoder (runs on each valid byte):
  - E0 sets ext.
  - F0 sets brk.
  - AA, FA, EE, FE, 00 and FF are dropped and clear ext/brk.
  - Any other byte: CODE_VALID=1, CODE=byte, CODE_EXT=ext, CODE_BREAK=brk; then clear ext/brk.
  - FRAME_ERR also clears ext/brk.
- Key table, for each i with {CODE_EXT,CODE}==KEY_CODES[i] on CODE_VALID:
  - brk=0: KEY_DOWN[i]←1. KEY_PRESS[i] pulses only if KEY_DOWN[i] was 0, so typematic repeats give no pulse.
  - brk=1: KEY_DOWN[i]←0.
  - Duplicate table entries update all matching indices identically.
  - Non-matching codes still produce CODE_VALID.
- ERR_COUNT increments by 1 on each FRAME_ERR and holds at 255.

## Timing
- Reset values: all outputs 0 and all counters 0. FSM in IDLE, ext=brk=0, previous-tick sample=1.
- RST mid-frame discards the partial frame and releases all keys with no pulses.
- PS2 sampling latency: 2 CLK of synchronisation plus up to CLK_DIV CLK of tick quantisation.
- Byte latency: CHECK occupies the tick after the 11th falling edge. CODE_VALID, FRAME_ERR, KEY_DOWN and KEY_PRESS register on the CLK edge ending that CHECK tick, all in the same cycle.
- At most one CODE_VALID per frame.
- Pulses never exceed one CLK. Successive pulses are ≥ 12 ticks apart.
- A falling edge arriving on the same tick as the timeout threshold counts as the edge; no timeout is raised.
- A byte F0 followed directly by E0 sets both ext and brk; the order of the prefixes does not matter.

## Test plan
- Sim parameters CLK_DIV=4, TIMEOUT_TICKS=40. Send frame 0x1C (start 0, data LSB-first, parity 0, stop 1) → one CODE_VALID with CODE=0x1C, EXT=0, BREAK=0. KEY_DOWN stays 0000.
- Send E0 75 → KEY_DOWN=0001 and KEY_PRESS=0001 for 1 CLK, with CODE_VALID and CODE_EXT=1. Send E0 75 again (repeat) → KEY_DOWN stays 0001 with no KEY_PRESS. Send E0 F0 75 → KEY_DOWN=0000, CODE_BREAK=1.
- Hold up (E0 75) and right (E0 74) together → KEY_DOWN=1001. Release right only → 0001.
- Send 0x1C with the parity bit flipped → FRAME_ERR pulse, no CODE_VALID, ERR_COUNT=1. Then send E0 followed by a bad frame, then 75 → CODE=0x75 with EXT=0 and KEY_DOWN unchanged.
- Send 5 falling edges, then idle 40 ticks → FRAME_ERR and ERR_COUNT+1. The next full 0x29 frame decodes correctly. Force 260 errors → ERR_COUNT=255.
- Assert RST while holding up and 6 bits into a frame → all outputs 0 the next CLK. The following E0 75 decodes cleanly.
